iter_muldiv: RTL

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/iter_muldiv_pkg.sv | 13 +
 rtl/iter_muldiv_divcore.sv | 52 +++++
 rtl/iter_muldiv.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package iter_muldiv_pkg;

  localparam int unsigned WordWidth = 64;

  // Encoding follows the RISC-V M-extension funct3 ordering.
  typedef enum logic [2:0] {
    MdMul, MdMulh, MdMulhsu, MdMulhu, MdDiv, MdDivu, MdRem, MdRemu
  } md_op_t;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_t;

endpackage

// File: rtl/iter_muldiv_divcore.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle.
module md_divcore #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic            is_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [6:0]      cnt_q;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, div_q};
    ge      = rem_sh >= {1'b0, div_q};
    quo_nxt = {quo_q[XLEN-2:0], ge};
    rem_nxt = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    last    = cnt_q == 7'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (load) begin
      // Word operands sit in the low half; move them up so the MSB shifts out first.
      quo_q <= (is_word && XLEN > 32) ? (dividend << 32) : dividend;
      rem_q <= '0;
      div_q <= divisor;
      cnt_q <= is_word ? 7'd32 : 7'(XLEN);
    end else if (cnt_q != 7'd0) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - 7'd1;
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiplier inline, restoring divider in md_divcore.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = WordWidth,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            start,
  input  md_op_t          op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned DW = 2 * XLEN;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
    logic [XLEN-1:0] r;
    r       = {XLEN{s}};
    r[31:0] = v;
    return r;
  endfunction

  md_state_t       state_q, state_d;
  md_op_t          op_q;
  logic            word_q, neg_q, neg_r_q;
  logic [DW-1:0]   acc_q, acc_d, mcand_q, prod;
  logic [XLEN-1:0] mplier_q, result_q;
  logic [6:0]      mcnt_q, mul_iters;

  logic            word_eff, a_signed, b_signed, sign_a, sign_b, is_div, b_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, spec_res, mul_res, div_res;
  logic [XLEN-1:0] quo_nxt, rem_nxt, qf, rf, sel;
  logic            div_last, accept;

  // Operand decode for a new request.
  always_comb begin
    is_div    = op[2];
    word_eff  = is_word && !(op inside {MdMulh, MdMulhsu, MdMulhu});
    a_signed  = op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
    b_signed  = op inside {MdMul, MdMulh, MdDiv, MdRem};
    a_ext     = word_eff ? ext32(a[31:0], a_signed && a[31]) : a;
    b_ext     = word_eff ? ext32(b[31:0], b_signed && b[31]) : b;
    sign_a    = a_signed && a_ext[XLEN-1];
    sign_b    = b_signed && b_ext[XLEN-1];
    mag_a     = sign_a ? -a_ext : a_ext;
    mag_b     = sign_b ? -b_ext : b_ext;
    min_val   = word_eff ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero    = is_div && (b_ext == '0);
    ovf       = (op inside {MdDiv, MdRem}) && (a_ext == min_val) && (b_ext == '1);
    special   = b_zero || ovf;
    spec_res  = '0;
    if (b_zero) spec_res = op[1] ? (word_eff ? ext32(a[31:0], a[31]) : a) : '1;
    else if (ovf) spec_res = op[1] ? '0 : a_ext;
    mul_iters = word_eff ? 7'(32 / MUL_BITS) : 7'(XLEN / MUL_BITS);
    accept    = (state_q == StIdle) && start && !flush;
  end

  // Multiply step and final fixups, evaluated on the edge that enters DONE.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
    prod    = neg_q ? -acc_d : acc_d;
    mul_res = (op_q == MdMul) ? (word_q ? ext32(prod[31:0], prod[31]) : prod[XLEN-1:0])
                              : prod[DW-1:XLEN];
    qf      = neg_q ? -quo_nxt : quo_nxt;
    rf      = neg_r_q ? -rem_nxt : rem_nxt;
    sel     = op_q[1] ? rf : qf;
    div_res = word_q ? ext32(sel[31:0], sel[31]) : sel;
  end

  md_divcore #(.XLEN(XLEN)) u_divcore (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (accept && is_div && !special),
    .is_word  (word_eff),
    .dividend (mag_a),
    .divisor  (mag_b),
    .last     (div_last),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = !is_div ? StMul : (special ? StDone : StDiv);
      StMul:   if (mcnt_q == 7'd1) state_d = StDone;
      StDiv:   if (div_last) state_d = StDone;
      StDone:  if (!stall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    busy   = (state_q == StMul) || (state_q == StDiv);
    done   = state_q == StDone;
    result = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= MdMul;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mcnt_q   <= '0;
      result_q <= '0;
    end else if (flush) begin
      mcnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: if (start) begin
          op_q     <= op;
          word_q   <= word_eff;
          neg_q    <= sign_a ^ sign_b;
          neg_r_q  <= sign_a;
          acc_q    <= '0;
          mcand_q  <= {{XLEN{1'b0}}, mag_a};
          mplier_q <= mag_b;
          mcnt_q   <= is_div ? 7'd0 : mul_iters;
          if (special) result_q <= spec_res;
        end
        StMul: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          mcnt_q   <= mcnt_q - 7'd1;
          if (mcnt_q == 7'd1) result_q <= mul_res;
        end
        StDiv: if (div_last) result_q <= div_res;
        default: ;
      endcase
    end
  end

endmodule
